// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge.
// Transfer types, responses, FSM states and size codes.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'd0,
      HRESP_ERROR = 2'd1
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_e;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/ahb_apb_strb.sv
// Byte-lane strobe and alignment check for one AHB beat.
// Sizes above a word are reported as illegal.
module ahb_apb_strb
   import ahb_apb_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr,
   output logic [3:0] strb,
   output logic       legal
);

   always_comb begin
      strb  = 4'b0000;
      legal = 1'b0;
      unique case (1'b1)
         (size == SIZE_BYTE): begin
            legal = 1'b1;
            strb  = 4'b0001 << addr;
         end
         (size == SIZE_HALF): begin
            legal = ~addr[0];
            strb  = addr[1] ? 4'b1100 : 4'b0011;
         end
         (size == SIZE_WORD): begin
            legal = (addr == 2'b00);
            strb  = 4'b1111;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite subordinate to APB4 requester, one beat outstanding.
// Each accepted beat becomes one APB transfer; HREADY stalls AHB.
module modport_bridge
   import ahb_apb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic [1:0]  HRESP,
   output logic [31:0] PADDR,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   output logic [2:0]  PPROT,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   bridge_state_e state, state_nx;
   logic [3:0]    strb;
   logic          legal;
   logic          active;
   logic          accept;
   logic          unused;

   assign unused = ^{HBURST, HPROT[3:2]};

   ahb_apb_strb u_strb (
      .size  (HSIZE),
      .addr  (HADDR[1:0]),
      .strb  (strb),
      .legal (legal)
   );

   assign active = htrans_e'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ};
   assign accept = HSEL & active & HREADY;

   always_ff @(posedge HCLK) begin
      if (!HRESETn)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_ERR2: begin
            if (!accept)
               state_nx = ST_IDLE;
            else if (!legal)
               state_nx = ST_ERR1;
            else if (HWRITE)
               state_nx = ST_WDATA;
            else
               state_nx = ST_SETUP;
         end
         ST_WDATA:  state_nx = ST_SETUP;
         ST_SETUP:  state_nx = ST_ACCESS;
         ST_ACCESS: begin
            if (PREADY)
               state_nx = PSLVERR ? ST_ERR1 : ST_IDLE;
         end
         ST_ERR1:   state_nx = ST_ERR2;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Handshake outputs decode the state register only.
   always_comb begin
      HREADY  = 1'b0;
      HRESP   = HRESP_OKAY;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      unique case (state)
         ST_IDLE:   HREADY = 1'b1;
         ST_WDATA:  ;
         ST_SETUP:  PSEL = 1'b1;
         ST_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         ST_ERR1:   HRESP = HRESP_ERROR;
         ST_ERR2: begin
            HREADY = 1'b1;
            HRESP  = HRESP_ERROR;
         end
         default:   HREADY = 1'b1;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PSTRB  <= '0;
         PPROT  <= '0;
         HRDATA <= '0;
      end else begin
         if (accept && legal) begin
            PADDR  <= HADDR;
            PWRITE <= HWRITE;
            PSTRB  <= HWRITE ? strb : 4'b0000;
            PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
         end
         if (state == ST_WDATA)
            PWDATA <= HWDATA;
         if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE)
            HRDATA <= PRDATA;
      end
   end

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for the AHB-Lite to APB4 bridge.
// Table of single beats plus hand-written idle/reset sequences.
module tb_modport_bridge;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd0;
   logic [2:0]  HBURST = 3'd0;
   logic [3:0]  HPROT = 4'd0;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b1;
   logic        PSLVERR = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 HCLK = ~HCLK;

   modport_bridge dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .HSEL    (HSEL),
      .HADDR   (HADDR),
      .HTRANS  (HTRANS),
      .HWRITE  (HWRITE),
      .HSIZE   (HSIZE),
      .HBURST  (HBURST),
      .HPROT   (HPROT),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .HREADY  (HREADY),
      .HRESP   (HRESP),
      .PADDR   (PADDR),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PWDATA  (PWDATA),
      .PSTRB   (PSTRB),
      .PPROT   (PPROT),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   typedef struct packed {
      logic        w;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  prot;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        slverr;
      logic [3:0]  waitn;
      logic [3:0]  low;
      logic        err;
      logic        psel;
      logic [3:0]  strb;
      logic [2:0]  pprot;
      logic [31:0] hrdata;
   } vec_t;

   vec_t v [14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_hready"}, {31'd0, HREADY}, 32'd1);
      chk({tag, "_hresp"}, {30'd0, HRESP}, 32'd0);
      chk({tag, "_hrdata"}, HRDATA, 32'd0);
      chk({tag, "_pctl"}, {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
      chk({tag, "_paddr"}, PADDR, 32'd0);
      chk({tag, "_pwdata"}, PWDATA, 32'd0);
      chk({tag, "_strb_prot"}, {25'd0, PSTRB, PPROT}, 32'd0);
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      int low;
      int acc;
      logic psel_seen;
      logic stable;
      logic [31:0] a_s;
      logic [31:0] wd_s;
      logic [3:0] strb_s;
      logic [2:0] prot_s;
      logic pw_s;
      logic pw_a;
      string n;
      n = $sformatf("v%0d", idx);
      low = 0;
      acc = 0;
      psel_seen = 1'b0;
      stable = 1'b1;
      a_s = 'x;
      wd_s = 'x;
      strb_s = 'x;
      prot_s = 'x;
      pw_s = 1'bx;
      pw_a = 1'bx;
      HSEL = 1'b1;
      HTRANS = 2'b10;
      HADDR = t.addr;
      HWRITE = t.w;
      HSIZE = t.size;
      HPROT = t.prot;
      PRDATA = t.rdata;
      PSLVERR = t.slverr;
      PREADY = (t.waitn == 4'd0);
      tick();
      HSEL = 1'b0;
      HTRANS = 2'b00;
      HWDATA = t.wdata;
      while (!HREADY && low < 40) begin
         low++;
         if (PSEL && !PENABLE) begin
            psel_seen = 1'b1;
            a_s = PADDR;
            wd_s = PWDATA;
            strb_s = PSTRB;
            prot_s = PPROT;
            pw_s = PWRITE;
         end
         if (PSEL && PENABLE) begin
            acc++;
            if (PADDR !== a_s) stable = 1'b0;
            pw_a = PWRITE;
            PREADY = (acc > int'(t.waitn));
         end
         tick();
      end
      PREADY = 1'b1;
      chk({n, "_done"}, {31'd0, HREADY}, 32'd1);
      chk({n, "_lowcycles"}, low, {28'd0, t.low});
      chk({n, "_hresp"}, {30'd0, HRESP}, {31'd0, t.err});
      chk({n, "_psel_seen"}, {31'd0, psel_seen}, {31'd0, t.psel});
      chk({n, "_hrdata"}, HRDATA, t.hrdata);
      if (t.psel) begin
         chk({n, "_paddr"}, a_s, t.addr);
         chk({n, "_paddr_stable"}, {31'd0, stable}, 32'd1);
         chk({n, "_pstrb"}, {28'd0, strb_s}, {28'd0, t.strb});
         chk({n, "_pprot"}, {29'd0, prot_s}, {29'd0, t.pprot});
         chk({n, "_pwrite"}, {30'd0, pw_s, pw_a}, {30'd0, t.w, t.w});
         if (t.w)
            chk({n, "_pwdata"}, wd_s, t.wdata);
      end
   endtask

   initial begin
      // w addr size prot wdata rdata slv wait low err psel strb pprot hrdata
      v[0]  = '{1'b0, 32'h10, 3'd2, 4'h3, 32'h0, 32'hDEADBEEF, 1'b0,
                4'd0, 4'd2, 1'b0, 1'b1, 4'h0, 3'b001, 32'hDEADBEEF};
      v[1]  = '{1'b1, 32'h20, 3'd2, 4'h0, 32'h12345678, 32'h0, 1'b0,
                4'd0, 4'd3, 1'b0, 1'b1, 4'hF, 3'b100, 32'hDEADBEEF};
      v[2]  = '{1'b1, 32'h03, 3'd0, 4'h1, 32'hAABBCCDD, 32'h0, 1'b0,
                4'd0, 4'd3, 1'b0, 1'b1, 4'h8, 3'b000, 32'hDEADBEEF};
      v[3]  = '{1'b1, 32'h06, 3'd1, 4'h2, 32'h55667788, 32'h0, 1'b0,
                4'd0, 4'd3, 1'b0, 1'b1, 4'hC, 3'b101, 32'hDEADBEEF};
      v[4]  = '{1'b1, 32'h00, 3'd1, 4'h1, 32'h01020304, 32'h0, 1'b0,
                4'd0, 4'd3, 1'b0, 1'b1, 4'h3, 3'b000, 32'hDEADBEEF};
      v[5]  = '{1'b1, 32'h01, 3'd0, 4'h3, 32'h0A0B0C0D, 32'h0, 1'b0,
                4'd0, 4'd3, 1'b0, 1'b1, 4'h2, 3'b001, 32'hDEADBEEF};
      v[6]  = '{1'b0, 32'h05, 3'd0, 4'h0, 32'h0, 32'h11223344, 1'b0,
                4'd0, 4'd2, 1'b0, 1'b1, 4'h0, 3'b100, 32'h11223344};
      v[7]  = '{1'b0, 32'h80, 3'd2, 4'h1, 32'h0, 32'h99887766, 1'b0,
                4'd3, 4'd5, 1'b0, 1'b1, 4'h0, 3'b000, 32'h99887766};
      v[8]  = '{1'b1, 32'h84, 3'd2, 4'h2, 32'hCAFEBABE, 32'h0, 1'b0,
                4'd2, 4'd5, 1'b0, 1'b1, 4'hF, 3'b101, 32'h99887766};
      v[9]  = '{1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1,
                4'd0, 4'd3, 1'b1, 1'b1, 4'h0, 3'b100, 32'h99887766};
      v[10] = '{1'b0, 32'h00, 3'd3, 4'h0, 32'h0, 32'h0, 1'b0,
                4'd0, 4'd1, 1'b1, 1'b0, 4'h0, 3'b000, 32'h99887766};
      v[11] = '{1'b1, 32'h01, 3'd1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0,
                4'd0, 4'd1, 1'b1, 1'b0, 4'h0, 3'b000, 32'h99887766};
      v[12] = '{1'b0, 32'h02, 3'd2, 4'h0, 32'h0, 32'h0, 1'b0,
                4'd0, 4'd1, 1'b1, 1'b0, 4'h0, 3'b000, 32'h99887766};
      v[13] = '{1'b0, 32'h44, 3'd2, 4'h1, 32'h0, 32'h55AA55AA, 1'b0,
                4'd0, 4'd2, 1'b0, 1'b1, 4'h0, 3'b000, 32'h55AA55AA};

      HRESETn = 1'b0;
      tick();
      tick();
      chk_reset("rst");
      HRESETn = 1'b1;
      tick();

      for (int i = 0; i < 14; i++)
         run_vec(v[i], i);

      // IDLE, BUSY and unselected beats get zero-wait OKAY
      HSEL = 1'b1;
      HTRANS = 2'b00;
      tick();
      chk("idle_beat", {29'd0, HREADY, HRESP}, 32'b100);
      HTRANS = 2'b01;
      tick();
      chk("busy_beat", {29'd0, HREADY, HRESP}, 32'b100);
      HSEL = 1'b0;
      HTRANS = 2'b10;
      tick();
      chk("unsel_beat", {30'd0, HREADY, PSEL}, 32'b10);
      HTRANS = 2'b00;

      // reset while the completer is stalling in ACCESS
      HSEL = 1'b1;
      HTRANS = 2'b10;
      HADDR = 32'h90;
      HWRITE = 1'b0;
      HSIZE = 3'd2;
      PREADY = 1'b0;
      tick();
      HSEL = 1'b0;
      HTRANS = 2'b00;
      tick();
      chk("mid_access", {29'd0, PSEL, PENABLE, HREADY}, 32'b110);
      HRESETn = 1'b0;
      tick();
      chk_reset("mid_rst");
      HRESETn = 1'b1;
      PREADY = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/modport_bridge.md
# modport_bridge

AHB-Lite subordinate to APB4 requester bridge. It sits behind the AHB `HSEL` decode and turns each accepted AHB beat into one APB transfer, stalling the AHB side with `HREADY` until the APB completer answers. It is a single-outstanding, non-buffered bridge; bursts are handled as independent beats.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `HCLK` input 1: the single clock; all logic is on its rising edge.
- `HRESETn` input 1: synchronous, active-low reset.
- `HSEL` input 1: bridge selected.
- `HADDR` input 32: AHB address.
- `HTRANS` input 2: transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- `HWRITE` input 1: 1 means write.
- `HSIZE` input 3: transfer size (0 byte, 1 half, 2 word).
- `HBURST` input 3: burst type; accepted but ignored.
- `HPROT` input 4: protection; mapped to `PPROT`.
- `HWDATA` input 32: write data, valid in the data phase.
- `HRDATA` output 32: read data.
- `HREADY` output 1: transfer done / bridge ready.
- `HRESP` output 2: 0 OKAY, 1 ERROR.
- `PADDR` output 32, `PSEL` output 1, `PENABLE` output 1, `PWRITE` output 1, `PWDATA` output 32, `PSTRB` output 4, `PPROT` output 3: APB requester outputs.
- `PRDATA` input 32, `PREADY` input 1, `PSLVERR` input 1: APB completer responses.

## Operation
- **Accept rule:** a transfer is accepted at a rising edge when `HSEL` = 1, `HTRANS[1]` = 1 and `HREADY` = 1. On acceptance, `HADDR`, `HWRITE`, `HSIZE` and `HPROT` are registered. IDLE and BUSY beats get zero-wait OKAY.
- **Size check:** if `HSIZE` > 2, or the address is misaligned for the size, there is no APB access. The bridge goes to ERR1.
- **FSM states:** IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: `HREADY` = 1. Accepted read goes to SETUP; accepted write goes to WDATA; illegal transfer goes to ERR1.
  - WDATA (writes only): `HREADY` = 0. Latch `HWDATA` into `PWDATA`, then go to SETUP.
  - SETUP: `PSEL` = 1, `PENABLE` = 0, `HREADY` = 0. Go to ACCESS.
  - ACCESS: `PSEL` = 1, `PENABLE` = 1, `HREADY` = 0. Hold while `PREADY` = 0. When `PREADY` = 1: with `PSLVERR` = 0, register `PRDATA` into `HRDATA` and go to IDLE (`HREADY` = 1, OKAY); with `PSLVERR` = 1, go to ERR1.
  - ERR1: `HREADY` = 0, `HRESP` = ERROR. Go to ERR2.
  - ERR2: `HREADY` = 1, `HRESP` = ERROR. Acts as IDLE for acceptance of the next transfer, except that an illegal transfer accepted here still goes to ERR1.
- **Back-to-back:** a new transfer may be accepted in the same cycle that the previous one completes.
- **`PSTRB`:** all zero for reads. For writes, derived from `HSIZE` and `HADDR[1:0]`: byte gives a one-hot strobe; half gives 0011 or 1100; word gives 1111.
- **`PPROT`:** `PPROT[0]` = `HPROT[1]` (privileged); `PPROT[1]` = 0 (secure); `PPROT[2]` = ~`HPROT[0]` (instruction).
- **`PADDR`** equals the registered `HADDR`.
- **`HRDATA`** holds its last value until the next read completes.

## Timing
- **Reset** (`HRESETn` = 0 at an edge): state = IDLE, `HREADY` = 1, `HRESP` = 0, `HRDATA` = 0, `PSEL` = `PENABLE` = `PWRITE` = 0, `PADDR` = `PWDATA` = 0, `PSTRB` = 0, `PPROT` = 0.
- **Reset mid-transfer:** the transfer is aborted immediately at the reset edge.
- **Latency, zero-wait completer:**
  - Read: `HREADY` is low for 2 cycles after the accepting edge.
  - Write: `HREADY` is low for 3 cycles after the accepting edge.
  - Each `PREADY` wait cycle adds one cycle.
- **Error latency:** an illegal transfer has 1 cycle of `HREADY` low with ERROR, then 1 cycle of `HREADY` high with ERROR.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `ahb_apb_pkg` holds:
  - the `htrans_e` and `hresp_e` encodings;
  - the `bridge_state_e` FSM enum;
  - the size constants.
- A single sub-module, `ahb_apb_strb`, is natural: a combinational `PSTRB`/alignment checker fed by `HSIZE` and `HADDR[1:0]`. Everything else lives in one FSM module.

## Test plan
- **Read, zero-wait:** NONSEQ read at 0x10 with `PRDATA` = 0xDEADBEEF → SETUP, then ACCESS, then `HREADY` = 1 with `HRDATA` = 0xDEADBEEF and `HRESP` = 0.
- **Word write:** write to 0x20 with `HWDATA` = 0x12345678 → `PWDATA` = 0x12345678, `PSTRB` = 1111, `PWRITE` = 1 in both APB phases.
- **Wait states:** `PREADY` low for 3 cycles → `PENABLE` and `HREADY` = 0 held for those 3 extra cycles, with no change to `PADDR`.
- **Completer error:** `PSLVERR` = 1 on a read → `HRESP` = 1 with `HREADY` 0, then `HRESP` = 1 with `HREADY` 1.
- **Illegal size:** `HSIZE` = 3, or a half-word at 0x01 → two-cycle ERROR response and `PSEL` never asserted.
- **Byte write and IDLE:** byte write at 0x03 → `PSTRB` = 1000. An IDLE beat → `HREADY` stays 1 with OKAY. Reset asserted in ACCESS → outputs return to reset values at the next edge.
